// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Memory-stage access controller between EX_MEM and MEM_WB.
//            Runs the load/store held in EX_MEM against a variable-latency
//            data memory over a req/ack handshake. It stalls the upstream
//            pipeline while the access is in flight, sends bubbles into
//            MEM_WB, and returns load data on rdata_out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   valid_in            EX_MEM holds a real instruction
//   mem_read_in         instruction is a load
//   mem_write_in        instruction is a store
//   addr_in, wdata_in   word address and store data from EX_MEM
//   mem_req/mem_wr      memory request (held while BUSY) and direction
//   mem_addr/mem_wdata  latched address and store data
//   mem_ack/mem_rdata   memory completion pulse and read data
//   rdata_out           load result toward MEM_WB MemRead_in
//   stall_out           freeze PC, IF_ID, ID_EX and EX_MEM
//   bubble_out          MEM_WB SendNOP_In
//   err_out             sticky access error (cleared only by reset)
// Optional : define MEM_ACC_TIMEOUT_EN to abort a BUSY access after
//            TIMEOUT_CYCLES cycles without mem_ack.
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              stall_out,
  output logic              bubble_out,
  output logic              err_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic w_legal;
  logic w_illegal;
  logic w_accept;
  logic w_reject;
  logic w_timeout;
  logic w_req;
  logic w_stall;
  logic w_bubble;

  assign w_legal   = valid_in & (mem_read_in ^ mem_write_in) & ~addr_in[0];
  assign w_illegal = valid_in & ((mem_read_in & mem_write_in) |
                                 ((mem_read_in | mem_write_in) & addr_in[0]));
  assign w_accept  = (r_state == S_IDLE) & w_legal;
  assign w_reject  = (r_state == S_IDLE) & w_illegal;

`ifdef MEM_ACC_TIMEOUT_EN
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tcnt;

  // Expiry only without ack: an ack on the same cycle is a normal completion.
  assign w_timeout = (r_state == S_BUSY) & ~mem_ack & (r_tcnt == C_TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= 16'd0;
    end else if (w_accept) begin
      r_tcnt <= 16'd0;
    end else if ((r_state == S_BUSY) && !mem_ack) begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          w_stall = 1'b1;
          w_next  = S_BUSY;
        end else if (w_illegal) begin
          w_bubble = 1'b1;
        end
      end
      S_BUSY: begin
        w_req    = 1'b1;
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (mem_ack || w_timeout) begin
          w_next = S_DONE;
        end
      end
      // EX_MEM and MEM_WB advance here, so the instruction is never re-issued.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mem_wr    <= mem_write_in;
        r_mem_addr  <= addr_in;
        r_mem_wdata <= wdata_in;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      if ((r_state == S_BUSY) && mem_ack && !r_mem_wr) begin
        r_rdata <= mem_rdata;
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= '1;
      end
    end
  end

  assign mem_req    = w_req;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign rdata_out  = r_rdata;
  assign stall_out  = w_stall;
  assign bubble_out = w_bubble;
  assign err_out    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// Optional : MEM_ACC_TIMEOUT_EN enables the timeout scenario (TIMEOUT_CYCLES=8).
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] rdata_out;
  logic        stall_out;
  logic        bubble_out;
  logic        err_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .rdata_out(rdata_out),
    .stall_out(stall_out),
    .bubble_out(bubble_out),
    .err_out(err_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    valid_in     = v;
    mem_read_in  = rd;
    mem_write_in = wr;
    addr_in      = a;
    wdata_in     = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    // Reset state (asynchronous, before any clock edge)
    chk("rst_req",    {15'd0, mem_req},    16'd0);
    chk("rst_stall",  {15'd0, stall_out},  16'd0);
    chk("rst_bubble", {15'd0, bubble_out}, 16'd0);
    chk("rst_err",    {15'd0, err_out},    16'd0);
    chk("rst_wr",     {15'd0, mem_wr},     16'd0);
    chk("rst_addr",   mem_addr,            16'h0000);
    chk("rst_wdata",  mem_wdata,           16'h0000);
    chk("rst_rdata",  rdata_out,           16'h0000);
    step();
    rst = 1'b0;
    step();

    // Load 0x0010, ack in the first BUSY cycle with 0xBEEF
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    #1;
    chk("ld_idle_stall",  {15'd0, stall_out},  16'd1);
    chk("ld_idle_bubble", {15'd0, bubble_out}, 16'd0);
    chk("ld_idle_req",    {15'd0, mem_req},    16'd0);
    step();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("ld_busy_req",    {15'd0, mem_req},    16'd1);
    chk("ld_busy_stall",  {15'd0, stall_out},  16'd1);
    chk("ld_busy_bubble", {15'd0, bubble_out}, 16'd1);
    chk("ld_busy_wr",     {15'd0, mem_wr},     16'd0);
    chk("ld_busy_addr",   mem_addr,            16'h0010);
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    #1;
    chk("ld_done_req",    {15'd0, mem_req},    16'd0);
    chk("ld_done_stall",  {15'd0, stall_out},  16'd0);
    chk("ld_done_bubble", {15'd0, bubble_out}, 16'd0);
    chk("ld_done_rdata",  rdata_out,           16'hBEEF);
    step();

    // Back-to-back store 0x0020 <- 0x1234 accepted in the IDLE after DONE; ack on 4th BUSY cycle
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234);
    #1;
    chk("st_idle_stall", {15'd0, stall_out}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack   = (i == 3);
      mem_rdata = 16'h5555;
      #1;
      chk("st_busy_req",   {15'd0, mem_req},   16'd1);
      chk("st_busy_stall", {15'd0, stall_out}, 16'd1);
      chk("st_busy_wr",    {15'd0, mem_wr},    16'd1);
      chk("st_busy_addr",  mem_addr,           16'h0020);
      chk("st_busy_wdata", mem_wdata,          16'h1234);
    end
    step();
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("st_done_stall", {15'd0, stall_out}, 16'd0);
    chk("st_done_req",   {15'd0, mem_req},   16'd0);
    chk("st_done_rdata", rdata_out,          16'hBEEF);
    step();

    // Unaligned load 0x0011
    drive(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000);
    #1;
    chk("ua_stall",  {15'd0, stall_out},  16'd0);
    chk("ua_bubble", {15'd0, bubble_out}, 16'd1);
    chk("ua_req",    {15'd0, mem_req},    16'd0);
    chk("ua_err0",   {15'd0, err_out},    16'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("ua_err1", {15'd0, err_out}, 16'd1);
    chk("ua_req1", {15'd0, mem_req}, 16'd0);

    // Load with both rd and wr set is also illegal
    drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000);
    #1;
    chk("rw_bubble", {15'd0, bubble_out}, 16'd1);
    chk("rw_stall",  {15'd0, stall_out},  16'd0);
    step();

    // Non-memory instruction with a spurious ack
    drive(1'b1, 1'b0, 1'b0, 16'h0033, 16'h7777);
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    #1;
    chk("nm_stall",  {15'd0, stall_out},  16'd0);
    chk("nm_bubble", {15'd0, bubble_out}, 16'd0);
    chk("nm_req",    {15'd0, mem_req},    16'd0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("nm_req2",  {15'd0, mem_req},   16'd0);
    chk("nm_rdata", rdata_out,          16'hBEEF);
    chk("nm_addr",  mem_addr,           16'h0020);
    chk("nm_err",   {15'd0, err_out},   16'd1);
    step();

    // Reset during BUSY cycle 2 of a load
    drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    step();
    step();
    chk("rm_busy_req", {15'd0, mem_req}, 16'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("rm_req",   {15'd0, mem_req},   16'd0);
    chk("rm_stall", {15'd0, stall_out}, 16'd0);
    chk("rm_err",   {15'd0, err_out},   16'd0);
    #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    step();
    mem_ack = 1'b0;
    #1;
    chk("rm_ack_req",   {15'd0, mem_req},   16'd0);
    chk("rm_ack_stall", {15'd0, stall_out}, 16'd0);
    chk("rm_ack_rdata", rdata_out,          16'h0000);
    step();

`ifdef MEM_ACC_TIMEOUT_EN
    // Timeout: load 0x0040, memory never acks
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_busy_req", {15'd0, mem_req}, 16'd1);
      chk("to_busy_err", {15'd0, err_out}, 16'd0);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    chk("to_done_err",   {15'd0, err_out},   16'd1);
    chk("to_done_rdata", rdata_out,          16'hFFFF);
    chk("to_done_req",   {15'd0, mem_req},   16'd0);
    chk("to_done_stall", {15'd0, stall_out}, 16'd0);
    step();
    chk("to_idle_req", {15'd0, mem_req}, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller between the EX_MEM pipeline register and MEM_WB.
- Takes the load/store request held in EX_MEM and runs it against a variable-latency data memory using a req/ack handshake.
- Stalls the upstream pipeline while the access is in flight, injects bubbles into MEM_WB, and delivers load data to MEM_WB's MemRead_in.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- TIMEOUT_CYCLES, 64, BUSY-cycle limit before abort; used only with MEM_ACC_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  EX_MEM holds a real instruction (not a NOP).
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- addr_in  in  ADDR_W  ALU result used as the word address.
- wdata_in  in  DATA_W  store data.
- mem_req  out  1  memory request, level-held while BUSY.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid while mem_ack = 1.
- rdata_out  out  DATA_W  load result to MEM_WB MemRead_in.
- stall_out  out  1  freeze PC, IF_ID, ID_EX and EX_MEM.
- bubble_out  out  1  to MEM_WB SendNOP_In.
- err_out  out  1  sticky access error.

Behaviour:
- Reset (async, immediate): state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata_out=0, err_out=0, timeout counter=0. Therefore stall_out=0 and bubble_out=0.
- An access is legal when valid_in=1, exactly one of mem_read_in / mem_write_in is 1, and addr_in[0]=0.
- An access is illegal when valid_in=1 and either (mem_read_in & mem_write_in) or ((mem_read_in | mem_write_in) & addr_in[0]).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Legal access: latch addr_in, wdata_in and mem_write_in into mem_addr, mem_wdata and mem_wr. Go to BUSY. stall_out=1 combinationally this cycle.
  - Illegal access: set err_out=1 and stay in IDLE. No memory request. No stall. bubble_out=1 so MEM_WB receives a NOP.
  - Otherwise (non-memory instruction or valid_in=0): pass through with stall_out=0 and bubble_out=0.
- BUSY:
  - mem_req=1, stall_out=1, bubble_out=1.
  - On mem_ack=1: if a read, rdata_out <= mem_rdata; go to DONE; mem_req drops on the next edge.
  - mem_ack is sampled only in BUSY; an ack in IDLE or DONE is ignored.
- DONE:
  - mem_req=0, stall_out=0, bubble_out=0.
  - EX_MEM and MEM_WB advance, carrying rdata_out into MEM_WB this edge.
  - Next state is always IDLE. The same instruction is never re-issued because EX_MEM advances in DONE.
- rdata_out holds its value until the next completed read.
- Store: rdata_out is unchanged.
- Latency: minimum 3 cycles per memory op (IDLE accept, BUSY with same-cycle ack, DONE); extra BUSY cycles equal the memory wait. Non-memory instructions add 0 cycles.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after DONE; there is no idle gap beyond that.
- err_out clears only on reset; the pipeline is expected to halt on it.
- Reset mid-access: async return to IDLE with mem_req=0 immediately; an in-flight ack after reset is ignored.

Optional Feature:
- Macro: MEM_ACC_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entry to BUSY, increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: set err_out=1, rdata_out <= 16'hFFFF, drop mem_req, go to DONE.
  - An ack on the expiry cycle wins: it is a normal completion with no error.
- Not defined: no counter; BUSY waits indefinitely for mem_ack.

Test Plan:
- Load addr 0x0010, memory acks 1 cycle after req with 0xBEEF: stall_out high for 2 cycles, mem_req high 1 cycle, rdata_out=0xBEEF in DONE, bubble_out low in DONE.
- Store addr 0x0020 data 0x1234, ack after 4 BUSY cycles: mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234 throughout BUSY; stall_out high 5 cycles; rdata_out unchanged.
- Unaligned load addr 0x0011: err_out=1 next edge, mem_req never asserted, stall_out=0, bubble_out=1 that cycle; err_out held until rst.
- Non-memory instruction stream (valid_in=1, rd=wr=0) with a spurious mem_ack pulse: stall_out=0, mem_req=0, outputs unchanged.
- Assert rst in BUSY cycle 2 of a load: mem_req and stall_out drop without waiting for clk; a later ack is ignored and the FSM stays in IDLE.
- With MEM_ACC_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack: err_out=1 and rdata_out=0xFFFF after 8 BUSY cycles, then DONE, then IDLE.
